fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0100: target address for traps and misaligned redirects.
REQ-003 clk  input  1  rising-edge clock; the only clock in the block.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address; equals pc while imem_req=1.
REQ-007 imem_gnt  input  1  memory accepts the request in the same cycle.
REQ-008 imem_rvalid  input  1  read data valid.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 redirect_valid  input  1  branch or jump taken, one-cycle pulse.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 trap_req  input  1  trap pulse; redirects fetch to TRAP_VEC.
REQ-013 stall  input  1  downstream cannot accept; hold the output.
REQ-014 if_valid  output  1  if_pc and if_instr are valid.
REQ-015 if_pc  output  32  address of the delivered instruction.
REQ-016 if_instr  output  32  delivered instruction.
REQ-017 misaligned  output  1  one-cycle flag: redirect_pc[1:0]!=0.

Function
REQ-018 The FSM SHALL have four states: IDLE, REQ, WAIT, HOLD.
REQ-019 IDLE SHALL last exactly one cycle after reset deasserts and then go to REQ.
REQ-020 In REQ:
  - imem_req=1, imem_addr=pc.
  - imem_gnt=1 goes to WAIT; otherwise stay in REQ with pc stable.
REQ-021 Only one request SHALL be outstanding; imem_req=0 in IDLE, WAIT and HOLD.
REQ-022 In WAIT, imem_rvalid=1 with no kill pending:
  - register if_instr<=imem_rdata, if_pc<=pc, if_valid<=1 next cycle.
  - pc<=pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - go to HOLD.
REQ-023 In HOLD:
  - stall=1 keeps if_valid, if_pc and if_instr unchanged.
  - stall=0 clears if_valid next cycle and goes to REQ.
REQ-024 Minimum latency from a grant to if_valid SHALL be rvalid cycle +1; with zero-wait memory the sustained rate is one instruction per 3 cycles.
REQ-025 Priority SHALL be trap_req > redirect_valid > sequential.
REQ-026 On a trap or redirect in any non-IDLE state:
  - pc<=TRAP_VEC or redirect_pc.
  - if_valid<=0 (flush).
  - go to REQ, except as in REQ-027.
REQ-027 If a request is in flight (state WAIT, or REQ with imem_gnt=1 in the same cycle):
  - set kill and stay in or enter WAIT.
  - the next rvalid SHALL be discarded: no if_valid, pc unchanged; clear kill, go to REQ.
REQ-028 Misaligned redirect (redirect_pc[1:0]!=0, no trap): pc<=TRAP_VEC and misaligned=1 for one cycle.
REQ-029 A redirect or trap during stall in HOLD SHALL flush regardless of stall.
REQ-030 A second redirect while kill is set SHALL overwrite pc; kill stays set and still discards exactly one response.
REQ-031 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-032 While rst=1 at a clock edge:
  - state=IDLE, pc=RESET_PC, kill=0.
  - if_valid=0, if_pc=0, if_instr=0, misaligned=0, imem_req=0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction; a late rvalid after reset SHALL be ignored under REQ-031.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enum, the RESET_PC/TRAP_VEC defaults and the instruction-width constant.
REQ-035 The PC register SHALL be a sub-module, fetch_pc_reg: synchronous active-high reset to RESET_PC, with load enable and next-value input.
REQ-036 All next-PC selection SHALL be in fetch_controller.

Verification
REQ-037 Reset release with memory granting immediately and rvalid the next cycle -> addresses 0x0, 0x4, 0x8 are requested; if_pc follows with if_valid pulses 3 cycles apart.
REQ-038 stall=1 for 5 cycles while in HOLD with if_pc=0x4 -> if_valid, if_pc and if_instr stay constant; no imem_req.
REQ-039 redirect_valid with redirect_pc=0x200 during WAIT -> that response is dropped; the next imem_addr is 0x200; no if_valid for the old address.
REQ-040 trap_req and redirect_valid (0x300) in the same cycle -> the next fetch is at 0x100.
REQ-041 redirect_pc=0x202 -> misaligned pulses once; the next fetch is at 0x100.
REQ-042 pc=0xFFFF_FFFC fetched -> the next imem_addr is 0x0000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default constants for the fetch controller
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;
    localparam int INSTR_W = 32;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter register with load enable
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] next_pc,
    output logic [31:0] pc
);
    always_ff @(posedge clk)
        if (rst) pc <= RESET_PC;
        else if (load) pc <= next_pc;
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: single-outstanding instruction fetch FSM with redirect, trap and kill handling
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               trap_req,
    input  logic               stall,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               misaligned
);
    state_t state, state_n;
    logic [31:0] pc, pc_n, if_pc_n;
    logic [INSTR_W-1:0] if_instr_n;
    logic pc_ld, kill, kill_n, if_valid_n, misaligned_n, flush, in_flight, deliver;

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .load(pc_ld), .next_pc(pc_n), .pc(pc)
    );

    assign imem_req  = state == REQ;
    assign imem_addr = pc;

    always_comb begin
        flush        = state != IDLE && (trap_req || redirect_valid);
        misaligned_n = flush && !trap_req && redirect_pc[1:0] != 2'b00;
        // a response returning this very cycle is already consumed, so it is not in flight
        in_flight    = (state == WAIT && !imem_rvalid) || (state == REQ && imem_gnt);
        deliver      = state == WAIT && imem_rvalid && !kill && !flush;
        state_n      = flush ? (in_flight ? WAIT : REQ) :
                       state == IDLE ? REQ :
                       state == REQ  ? (imem_gnt ? WAIT : REQ) :
                       state == WAIT ? (imem_rvalid ? (kill ? REQ : HOLD) : WAIT) :
                       (stall ? HOLD : REQ);
        kill_n       = flush ? in_flight : (state == WAIT && imem_rvalid) ? 1'b0 : kill;
        pc_ld        = flush || deliver;
        pc_n         = flush ? ((trap_req || misaligned_n) ? TRAP_VEC : redirect_pc) : pc + 32'd4;
        if_valid_n   = flush ? 1'b0 : deliver ? 1'b1 : (state == HOLD && !stall) ? 1'b0 : if_valid;
        if_pc_n      = deliver ? pc : if_pc;
        if_instr_n   = deliver ? imem_rdata : if_instr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            kill       <= 1'b0;
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_instr   <= '0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_n;
            kill       <= kill_n;
            if_valid   <= if_valid_n;
            if_pc      <= if_pc_n;
            if_instr   <= if_instr_n;
            misaligned <= misaligned_n;
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed and random checks of fetch_controller against a transaction-level model
module tb_fetch_controller;
    logic clk = 1'b0;
    logic rst, imem_req, imem_gnt, imem_rvalid, redirect_valid, trap_req, stall, if_valid, misaligned;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, if_pc, if_instr;
    localparam logic [31:0] TRAP = 32'h0000_0100;
    int n_assert = 0, n_fail = 0;
    bit m_started, m_busy, m_valid, m_kill, m_mis;
    logic [31:0] m_pc, m_ipc, m_instr, held;

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap_req(trap_req),
        .stall(stall), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .misaligned(misaligned)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // a new request is issued whenever fetch has started, nothing is outstanding and nothing is held
    function automatic bit m_req();
        return m_started && !m_busy && !m_valid;
    endfunction

    task automatic step(bit r, bit g, bit v, logic [31:0] d, bit rd, logic [31:0] rp, bit t, bit s);
        bit granted;
        rst = r; imem_gnt = g; imem_rvalid = v; imem_rdata = d;
        redirect_valid = rd; redirect_pc = rp; trap_req = t; stall = s;
        granted = m_req() && g;
        if (r) begin
            m_started = 0; m_busy = 0; m_valid = 0; m_kill = 0; m_mis = 0;
            m_pc = 32'h0; m_ipc = 32'h0; m_instr = 32'h0;
        end else if (!m_started) begin
            m_started = 1; m_mis = 0;
        end else if (t || rd) begin
            m_mis   = !t && rp[1:0] != 2'b00;
            m_pc    = (t || m_mis) ? TRAP : rp;
            m_valid = 0;
            m_busy  = (m_busy && !v) || granted;
            m_kill  = m_busy;
        end else begin
            m_mis = 0;
            if (m_busy && v) begin
                m_busy = 0;
                if (m_kill) m_kill = 0;
                else begin
                    m_valid = 1; m_ipc = m_pc; m_instr = d; m_pc = m_pc + 32'd4;
                end
            end else if (granted) m_busy = 1;
            else if (m_valid && !s) m_valid = 0;
        end
        @(posedge clk); #1;
        chk("imem_req", 32'(imem_req), 32'(m_req()));
        if (m_req()) chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", 32'(if_valid), 32'(m_valid));
        chk("if_pc", if_pc, m_ipc);
        chk("if_instr", if_instr, m_instr);
        chk("misaligned", 32'(misaligned), 32'(m_mis));
    endtask

    task automatic goto_req();
        for (int i = 0; i < 20 && !m_req(); i++) step(0, 1, 1, $urandom, 0, 0, 0, 0);
    endtask

    task automatic goto_wait();
        for (int i = 0; i < 20 && !m_busy; i++) step(0, 1, 0, $urandom, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] rnd_pc, rnd_lo;
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_valid", 32'(if_valid), 32'h0);
        repeat (10) step(0, 1, 1, $urandom, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && !(m_valid && m_ipc == 32'h4); i++) step(0, 1, 1, $urandom, 0, 0, 0, 0);
        chk("hold_pc4", if_pc, 32'h4);
        held = m_instr;
        repeat (5) begin
            step(0, 1, 1, $urandom, 0, 0, 0, 1);
            chk("stall_pc", if_pc, 32'h4);
            chk("stall_valid", 32'(if_valid), 32'h1);
            chk("stall_instr", if_instr, held);
            chk("stall_req", 32'(imem_req), 32'h0);
        end
        goto_wait();
        step(0, 0, 0, 0, 1, 32'h200, 0, 0);
        goto_req();
        chk("redirect_addr", imem_addr, 32'h200);
        step(0, 1, 0, 0, 1, 32'h300, 1, 0);
        goto_req();
        chk("trap_addr", imem_addr, TRAP);
        step(0, 0, 0, 0, 1, 32'h202, 0, 0);
        chk("misaligned_pulse", 32'(misaligned), 32'h1);
        chk("misaligned_addr", imem_addr, TRAP);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("misaligned_clear", 32'(misaligned), 32'h0);
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, $urandom, 0, 0, 0, 0);
        goto_req();
        chk("wrap_addr", imem_addr, 32'h0);
        repeat (3000) begin
            rnd_pc = $urandom;
            rnd_lo = $urandom_range(3) == 0 ? $urandom : 32'h0;
            step($urandom_range(63) == 0, $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom,
                 $urandom_range(7) == 0, {rnd_pc[31:2], rnd_lo[1:0]}, $urandom_range(15) == 0,
                 $urandom_range(2) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
